mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the Fetch stage (instruction port) and the Mem stage
//  (data port). It arbitrates requests and sequences each fixed-latency memory access with an FSM.
//  It returns read data and a one-cycle ready pulse, and drives the stall signals that freeze the
//  IF/ID and EX/MEM pipeline registers while an access is pending.
// PARAMETERS
//  ADDR_W         32  address width
//  DATA_W         32  data width (byte strobes = DATA_W/8)
//  MEM_LAT        2   cycles from mem_req to valid mem_rdata; legal 1..7
//  PRIORITY_MODE  0   0 = data port always wins ties; 1 = round-robin on ties
// PORTS
//  clk        in   1         clock, all state updates on posedge
//  reset      in   1         synchronous, active-high
//  if_req     in   1         fetch read request, held until if_ready
//  if_addr    in   ADDR_W    fetch address
//  if_rdata   out  DATA_W    fetched instruction, valid while if_ready=1
//  if_ready   out  1         one-cycle completion pulse for fetch
//  d_req      in   1         data request, held until d_ready
//  d_we       in   1         1 = store, 0 = load
//  d_addr     in   ADDR_W    data address
//  d_wdata    in   DATA_W    store data
//  d_wstrb    in   DATA_W/8  store byte enables
//  d_rdata    out  DATA_W    load data, valid while d_ready=1
//  d_ready    out  1         one-cycle completion pulse for data
//  mem_req    out  1         memory access strobe, one cycle per access
//  mem_we     out  1         memory write enable
//  mem_addr   out  ADDR_W    memory address
//  mem_wdata  out  DATA_W    memory write data
//  mem_wstrb  out  DATA_W/8  memory byte enables
//  mem_rdata  in   DATA_W    memory read data, valid MEM_LAT cycles after mem_req
//  stall_f    out  1         if_req & ~if_ready; freezes Fetch and IF/ID
//  stall_m    out  1         d_req & ~d_ready; freezes the pipe behind Mem
// BEHAVIOUR
//  - FSM states: IDLE, WAIT, DONE. Registers: owner (I/D), cnt[2:0], last_grant.
//  - Grant (combinational): legal only in IDLE, or in DONE for the non-owner port.
//    The port completing in DONE is never re-granted that cycle, so a held req cannot duplicate.
//    Grant cycle T: mem_req=1 and mem_addr/we/wdata/wstrb come from the winner.
//    If no grant: mem_req=0, mem_we=0, all mem_* buses = 0.
//  - Tie, mode 0: data port wins. Tie, mode 1: port != last_grant wins.
//    last_grant updates on every grant; its reset value is I, so the first tie goes to D.
//  - Read grant at T -> WAIT at T+1, cnt=MEM_LAT-1. cnt decrements each cycle in WAIT.
//    In WAIT with cnt==0 (cycle T+MEM_LAT): capture mem_rdata into the owner's rdata reg, go to DONE.
//    ready/rdata are valid at T+MEM_LAT+1 for exactly one cycle. Read latency = MEM_LAT+1.
//  - Store grant at T -> DONE at T+1 with d_ready=1. d_rdata keeps its previous value.
//  - DONE: owner's ready=1 for one cycle.
//    Then -> WAIT if a read was granted, -> DONE (other owner) if a store was granted, else -> IDLE.
//  - if_rdata/d_rdata are registered and hold their value between accesses.
//  - Req/addr changes while WAIT are ignored; requesters must hold req/addr until ready.
//  - Reset values: state IDLE, cnt 0, last_grant I, if_rdata/d_rdata 0, if_ready/d_ready 0,
//    mem_* 0. stall_f/stall_m are forced 0 while reset=1.
//  - Reset mid-access: next cycle is IDLE. The pending ready pulse is suppressed and the in-flight
//    mem_rdata is discarded. A req still held after reset is re-arbitrated from scratch.
//  - cnt never wraps: it is loaded only on a read grant and is only read in WAIT.
// TESTING
//  1 MEM_LAT=2: if_req, addr 0x100 at cyc0; mem_rdata=0x00500093 at cyc2 -> mem_req/addr 0x100 at cyc0;
//    if_ready=1 with if_rdata=0x00500093 at cyc3 only; stall_f=1 cyc0-2.
//  2 Mode 0, if_req+d_req(load 0x40) at cyc0 -> D granted cyc0, d_ready cyc3; I granted cyc3 in DONE;
//    if_ready cyc6; no idle bubble between accesses.
//  3 Store: d_we=1, addr 0x40, wdata 0xDEADBEEF, wstrb 0xF -> mem_we=1 with those values at cyc0;
//    d_ready cyc1; d_rdata unchanged.
//  4 Mode 1, both reqs held for 4 accesses -> grant order D,I,D,I; each ready pulses exactly once.
//  5 Read granted cyc0, reset=1 at cyc1 -> IDLE at cyc2; no ready at cyc3; all outputs 0 during reset.
//  6 Random mix of fetches/loads/stores with MEM_LAT 1..7 vs. memory model: data integrity,
//    one mem_req per access, and no starvation in mode 1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-port, fixed-latency memory between the fetch (I) and data (D) ports.
// A three-state FSM sequences each access and returns registered read data with a one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MEM_LAT       = 2,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_f,
  output logic                stall_m,
  output logic [1:0]          dbg_state
);

  // Handshake: a port raises req with stable addr/data and holds it until its ready pulse;
  // ready is high for exactly one cycle per accepted access, and rdata is valid in that cycle.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] CNT_LOAD = 3'(MEM_LAT - 1);

  state_t            state;
  state_t            stateNext;
  logic              owner;      // 1 = data port owns the current access
  logic              lastGrant;  // 1 = data port won the most recent grant
  logic [2:0]        cnt;
  logic [DATA_W-1:0] ifRdataQ;
  logic [DATA_W-1:0] dRdataQ;
  logic              eligI;
  logic              eligD;
  logic              grantI;
  logic              grantD;
  logic              grant;
  logic              grantRead;

  // In DONE only the port that is not completing may be granted, so a held req never repeats.
  always_comb begin
    eligI = 1'b0;
    eligD = 1'b0;
    if (!reset) begin
      if (state == IDLE) begin
        eligI = if_req;
        eligD = d_req;
      end else if (state == DONE) begin
        eligI = if_req && owner;
        eligD = d_req && !owner;
      end
    end
    grantD    = eligD && (!eligI || (PRIORITY_MODE == 0) || !lastGrant);
    grantI    = eligI && !grantD;
    grant     = grantI || grantD;
    grantRead = grantI || (grantD && !d_we);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (grant) stateNext = grantRead ? WAIT : DONE;
      WAIT:    if (cnt == 3'd0) stateNext = DONE;
      DONE:    if (grant) stateNext = grantRead ? WAIT : DONE;
               else       stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= 1'b0;
      lastGrant <= 1'b0;
      cnt       <= 3'd0;
      ifRdataQ  <= '0;
      dRdataQ   <= '0;
    end else begin
      if (grant) begin
        owner     <= grantD;
        lastGrant <= grantD;
        if (grantRead) cnt <= CNT_LOAD;
      end else if (state == WAIT && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      // The memory word is valid exactly in the last WAIT cycle.
      if (state == WAIT && cnt == 3'd0) begin
        if (owner) dRdataQ  <= mem_rdata;
        else       ifRdataQ <= mem_rdata;
      end
    end
  end

  always_comb begin
    if_ready  = !reset && (state == DONE) && !owner;
    d_ready   = !reset && (state == DONE) && owner;
    mem_req   = grant;
    mem_we    = grantD && d_we;
    mem_addr  = grantD ? d_addr : (grantI ? if_addr : '0);
    mem_wdata = grantD ? d_wdata : '0;
    mem_wstrb = grantD ? d_wstrb : '0;
    if_rdata  = reset ? '0 : ifRdataQ;
    d_rdata   = reset ? '0 : dRdataQ;
    stall_f   = !reset && if_req && !if_ready;
    stall_m   = !reset && d_req && !d_ready;
    dbg_state = state;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: several latency/priority configurations run the same request script,
// each against a timestamp-level model of the arbiter and a behavioural memory.
module tb_mem_port_arbiter;

  localparam int NCFG = 5;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  gap;
  } fop_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  gap;
  } dop_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   nChecks = 0;
  int   nFails = 0;
  int   phaseId = 0;
  int   doneCount = 0;
  fop_t fOps[$];
  dop_t dOps[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int latOf(input int k);
    case (k)
      0: return 2;
      1: return 2;
      2: return 5;
      3: return 7;
      default: return 1;
    endcase
  endfunction

  function automatic int modeOf(input int k);
    return (k == 0 || k == 3) ? 0 : 1;
  endfunction

  function automatic logic [31:0] initWord(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] mergeW(input logic [31:0] o, input logic [31:0] w,
                                         input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic addF(input logic [31:0] a, input logic [3:0] g);
    fop_t f;
    f.addr = a;
    f.gap  = g;
    fOps.push_back(f);
  endtask

  task automatic addD(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [3:0] g);
    dop_t d;
    d.we = we; d.addr = a; d.wdata = wd; d.wstrb = st; d.gap = g;
    dOps.push_back(d);
  endtask

  task automatic startPhase();
    doneCount = 0;
    phaseId++;
  endtask

  task automatic waitPhase();
    int t;
    t = 0;
    while (doneCount < 2*NCFG && t < 4000) begin
      @(posedge clk);
      t++;
    end
    chk("phase_done", doneCount, 2*NCFG);
    repeat (3) @(posedge clk);
    #1;
    fOps.delete();
    dOps.delete();
  endtask

  // ---------------- per-configuration harness ----------------
  for (genvar k = 0; k < NCFG; k++) begin : g
    localparam int LAT  = latOf(k);
    localparam int MODE = modeOf(k);

    logic        ifReq, ifReady, dReq, dWe, dReady, memReq, memWe, stallF, stallM;
    logic [31:0] ifAddr, ifRdata, dAddr, dWdata, dRdata, memAddr, memWdata, memRdata;
    logic [3:0]  dWstrb, memWstrb;
    logic [1:0]  dbgState;

    mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .PRIORITY_MODE(MODE)
    ) dut (
      .clk(clk), .reset(reset),
      .if_req(ifReq), .if_addr(ifAddr), .if_rdata(ifRdata), .if_ready(ifReady),
      .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata), .d_wstrb(dWstrb),
      .d_rdata(dRdata), .d_ready(dReady),
      .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
      .mem_wstrb(memWstrb), .mem_rdata(memRdata),
      .stall_f(stallF), .stall_m(stallM), .dbg_state(dbgState)
    );

    // Behavioural memory: applies stores on the bus and returns read data LAT cycles later,
    // driving noise on every other cycle.
    logic [31:0] memArr [logic [31:0]];
    int          dueQ[$];
    logic [31:0] datQ[$];

    initial forever begin
      @(negedge clk);
      if (memReq) begin
        if (memWe) begin
          memArr[memAddr] = mergeW(memArr.exists(memAddr) ? memArr[memAddr] : initWord(memAddr),
                                   memWdata, memWstrb);
        end else begin
          dueQ.push_back(cyc + LAT);
          datQ.push_back(memArr.exists(memAddr) ? memArr[memAddr] : initWord(memAddr));
        end
      end
    end

    initial begin
      memRdata = '0;
      forever begin
        @(posedge clk);
        #1;
        while (dueQ.size() > 0 && dueQ[0] < cyc) begin
          void'(dueQ.pop_front());
          void'(datQ.pop_front());
        end
        if (dueQ.size() > 0 && dueQ[0] == cyc) begin
          memRdata = datQ.pop_front();
          void'(dueQ.pop_front());
        end else begin
          memRdata = $urandom;
        end
      end
    end

    // Requesters: each holds req until its ready pulse, then idles for the op's gap.
    initial begin : fetchAgent
      int wd;
      ifReq = 1'b0;
      ifAddr = '0;
      forever begin
        @(phaseId);
        for (int i = 0; i < fOps.size(); i++) begin
          repeat (fOps[i].gap) begin @(posedge clk); #1; end
          ifReq = 1'b1;
          ifAddr = fOps[i].addr;
          wd = 0;
          do begin @(negedge clk); wd++; end while (!ifReady && wd < 100);
          chk($sformatf("c%0d.if_wait_bound", k), 32'(wd <= 2*LAT + 4), 32'd1);
          @(posedge clk);
          #1;
          ifReq = 1'b0;
          ifAddr = $urandom;
        end
        doneCount++;
      end
    end

    initial begin : dataAgent
      int wd;
      dReq = 1'b0; dWe = 1'b0; dAddr = '0; dWdata = '0; dWstrb = '0;
      forever begin
        @(phaseId);
        for (int i = 0; i < dOps.size(); i++) begin
          repeat (dOps[i].gap) begin @(posedge clk); #1; end
          dReq = 1'b1;
          dWe = dOps[i].we; dAddr = dOps[i].addr; dWdata = dOps[i].wdata; dWstrb = dOps[i].wstrb;
          wd = 0;
          do begin @(negedge clk); wd++; end while (!dReady && wd < 100);
          chk($sformatf("c%0d.d_wait_bound", k), 32'(wd <= 2*LAT + 4), 32'd1);
          @(posedge clk);
          #1;
          dReq = 1'b0;
          dWe = 1'($urandom); dAddr = $urandom; dWdata = $urandom; dWstrb = 4'($urandom);
        end
        doneCount++;
      end
    end

    // Model: the memory is busy until a known completion cycle; a grant is possible when idle
    // or in the completion cycle for the other port. Expected outputs are checked every cycle.
    logic [31:0] shadow [logic [31:0]];
    logic [31:0] expQ[$];

    initial begin : model
      logic        busy, ownD, isRd, lastD, rdyNow, freeNow, eI, eD, winD, gnt;
      logic        xReq, xWe, xIfRdy, xDRdy, xSf, xSm;
      logic [31:0] a, xAd, xWd, rIf, rD;
      logic [3:0]  xSt;
      int          readyCyc;
      string       p;
      busy = 1'b0; ownD = 1'b0; isRd = 1'b0; lastD = 1'b0; readyCyc = 0; rIf = '0; rD = '0;
      p = $sformatf("c%0d.", k);
      forever begin
        @(negedge clk);
        xReq = 1'b0; xWe = 1'b0; xAd = '0; xWd = '0; xSt = '0;
        xIfRdy = 1'b0; xDRdy = 1'b0; xSf = 1'b0; xSm = 1'b0;
        if (reset) begin
          busy = 1'b0; lastD = 1'b0; rIf = '0; rD = '0;
          expQ.delete();
        end else begin
          rdyNow = busy && (cyc == readyCyc);
          if (rdyNow && isRd) begin
            if (ownD) rD = expQ.pop_front();
            else      rIf = expQ.pop_front();
          end
          xIfRdy  = rdyNow && !ownD;
          xDRdy   = rdyNow && ownD;
          freeNow = !busy || rdyNow;
          eI      = ifReq && freeNow && !xIfRdy;
          eD      = dReq && freeNow && !xDRdy;
          winD    = eD && (!eI || MODE == 0 || !lastD);
          gnt     = eI || eD;
          xSf     = ifReq && !xIfRdy;
          xSm     = dReq && !xDRdy;
          if (gnt) begin
            a    = winD ? dAddr : ifAddr;
            xReq = 1'b1;
            xAd  = a;
            xWe  = winD && dWe;
            if (winD) begin xWd = dWdata; xSt = dWstrb; end
            busy = 1'b1; ownD = winD; lastD = winD; isRd = !xWe;
            if (isRd) begin
              expQ.push_back(shadow.exists(a) ? shadow[a] : initWord(a));
              readyCyc = cyc + LAT + 1;
            end else begin
              shadow[a] = mergeW(shadow.exists(a) ? shadow[a] : initWord(a), dWdata, dWstrb);
              readyCyc = cyc + 1;
            end
          end else if (rdyNow) begin
            busy = 1'b0;
          end
        end
        chk({p, "if_ready"},  ifReady,  xIfRdy);
        chk({p, "d_ready"},   dReady,   xDRdy);
        chk({p, "if_rdata"},  ifRdata,  rIf);
        chk({p, "d_rdata"},   dRdata,   rD);
        chk({p, "mem_req"},   memReq,   xReq);
        chk({p, "mem_we"},    memWe,    xWe);
        chk({p, "mem_addr"},  memAddr,  xAd);
        chk({p, "mem_wdata"}, memWdata, xWd);
        chk({p, "mem_wstrb"}, memWstrb, xSt);
        chk({p, "stall_f"},   stallF,   xSf);
        chk({p, "stall_m"},   stallM,   xSm);
      end
    end
  end

  // ---------------- directed script + hand-computed expectations ----------------
  initial begin
    reset = 1'b1;
    @(negedge clk);
    chk("rst.mem_req", g[0].memReq, 0);
    @(negedge clk);
    chk("rst.state", g[0].dbgState, 0);
    chk("rst.if_rdata", g[0].ifRdata, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Single fetch, MEM_LAT=2
    addF(32'h100, 0);
    startPhase();
    @(negedge clk);
    chk("t1.mem_req", g[0].memReq, 1);
    chk("t1.mem_addr", g[0].memAddr, 32'h100);
    chk("t1.stall_f0", g[0].stallF, 1);
    @(negedge clk);
    chk("t1.ready1", g[0].ifReady, 0);
    @(negedge clk);
    chk("t1.stall_f2", g[0].stallF, 1);
    @(negedge clk);
    chk("t1.ready3", g[0].ifReady, 1);
    chk("t1.rdata3", g[0].ifRdata, 32'h0050_0093);
    chk("t1.stall_f3", g[0].stallF, 0);
    @(negedge clk);
    chk("t1.ready4", g[0].ifReady, 0);
    waitPhase();

    // Both ports held for two accesses each: order D,I,D,I in both priority modes
    addF(32'h300, 0); addF(32'h304, 0);
    addD(0, 32'h44, 32'h0, 4'h0, 0); addD(0, 32'h48, 32'h0, 4'h0, 0);
    startPhase();
    @(negedge clk);
    chk("t4.m1_addr0", g[1].memAddr, 32'h44);
    chk("t4.m0_addr0", g[0].memAddr, 32'h44);
    repeat (3) @(negedge clk);
    chk("t4.m1_addr3", g[1].memAddr, 32'h300);
    chk("t4.m1_dready3", g[1].dReady, 1);
    chk("t4.m1_drdata3", g[1].dRdata, 32'h0044_FFBB);
    repeat (3) @(negedge clk);
    chk("t4.m1_addr6", g[1].memAddr, 32'h48);
    chk("t4.m1_ifready6", g[1].ifReady, 1);
    chk("t4.m1_ifrdata6", g[1].ifRdata, 32'h0300_FCFF);
    repeat (3) @(negedge clk);
    chk("t4.m1_addr9", g[1].memAddr, 32'h304);
    chk("t4.m1_drdata9", g[1].dRdata, 32'h0048_FFB7);
    repeat (3) @(negedge clk);
    chk("t4.m1_ifrdata12", g[1].ifRdata, 32'h0304_FCFB);
    waitPhase();

    // Tie in mode 0: load wins, fetch follows with no idle bubble
    addF(32'h200, 0);
    addD(0, 32'h40, 32'h0, 4'h0, 0);
    startPhase();
    @(negedge clk);
    chk("t2.addr0", g[0].memAddr, 32'h40);
    chk("t2.we0", g[0].memWe, 0);
    @(negedge clk);
    chk("t2.stall_m1", g[0].stallM, 1);
    repeat (2) @(negedge clk);
    chk("t2.dready3", g[0].dReady, 1);
    chk("t2.drdata3", g[0].dRdata, 32'h0040_FFBF);
    chk("t2.req3", g[0].memReq, 1);
    chk("t2.addr3", g[0].memAddr, 32'h200);
    chk("t2.stall_m3", g[0].stallM, 0);
    repeat (3) @(negedge clk);
    chk("t2.ifready6", g[0].ifReady, 1);
    chk("t2.ifrdata6", g[0].ifRdata, 32'h0200_FDFF);
    waitPhase();

    // Store: one-cycle completion, load data register untouched
    addD(1, 32'h40, 32'hDEAD_BEEF, 4'hF, 0);
    startPhase();
    @(negedge clk);
    chk("t3.we0", g[0].memWe, 1);
    chk("t3.addr0", g[0].memAddr, 32'h40);
    chk("t3.wdata0", g[0].memWdata, 32'hDEAD_BEEF);
    chk("t3.wstrb0", g[0].memWstrb, 4'hF);
    @(negedge clk);
    chk("t3.dready1", g[0].dReady, 1);
    chk("t3.drdata1", g[0].dRdata, 32'h0040_FFBF);
    chk("t3.req1", g[0].memReq, 0);
    @(negedge clk);
    chk("t3.dready2", g[0].dReady, 0);
    waitPhase();

    // Reset in the middle of a read: pulse suppressed, held req re-arbitrated
    addF(32'h100, 0);
    startPhase();
    @(negedge clk);
    chk("t5.req0", g[0].memReq, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t5.rst_req", g[0].memReq, 0);
    chk("t5.rst_stall", g[0].stallF, 0);
    chk("t5.rst_ifrdata", g[0].ifRdata, 0);
    chk("t5.rst_ifready", g[0].ifReady, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t5.state2", g[0].dbgState, 0);
    chk("t5.regrant2", g[0].memReq, 1);
    @(negedge clk);
    chk("t5.ready3", g[0].ifReady, 0);
    repeat (2) @(negedge clk);
    chk("t5.ready5", g[0].ifReady, 1);
    chk("t5.rdata5", g[0].ifRdata, 32'h0050_0093);
    waitPhase();

    // Mixed traffic on a small shared address pool
    for (int i = 0; i < 30; i++)
      addF({26'd0, 4'($urandom_range(0, 15)), 2'b00}, 4'($urandom_range(0, 3)));
    for (int i = 0; i < 30; i++)
      addD(($urandom_range(0, 2) == 0), {26'd0, 4'($urandom_range(0, 15)), 2'b00},
           $urandom, 4'($urandom_range(1, 15)), 4'($urandom_range(0, 3)));
    startPhase();
    waitPhase();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
